// File: rtl/barrel_arbiter_pkg.sv
// rtl/barrel_arbiter_pkg.sv - shared constants and types for the barrel shifter arbiter
package barrel_arbiter_pkg;

    localparam int W  = 16;
    localparam int SW = 4;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/barrel_arbiter_if.sv
// rtl/barrel_arbiter_if.sv - two-requester shift request/response bundle
interface barrel_arbiter_if;
    import barrel_arbiter_pkg::*;

    logic          req0;
    logic [1:0]    type0;
    logic [SW-1:0] amt0;
    logic [W-1:0]  din0;
    logic          ack0;
    logic          req1;
    logic [1:0]    type1;
    logic [SW-1:0] amt1;
    logic [W-1:0]  din1;
    logic          ack1;
    logic [W-1:0]  result;
    logic          done;
    logic          done_id;
    logic          busy;

    modport master (
        output req0, type0, amt0, din0,
        output req1, type1, amt1, din1,
        input  ack0, ack1, result, done, done_id, busy
    );

    modport slave (
        input  req0, type0, amt0, din0,
        input  req1, type1, amt1, din1,
        output ack0, ack1, result, done, done_id, busy
    );

endinterface

// File: rtl/barrel_arbiter_shifter.sv
// rtl/barrel_arbiter_shifter.sv - combinational 16-bit lsl/lsr/asr/ror barrel shifter
module barrel_arbiter_shifter
    import barrel_arbiter_pkg::*;
(
    input  logic [1:0]    shift_type,
    input  logic [SW-1:0] shift,
    input  logic [W-1:0]  data_in,
    output logic [W-1:0]  data_out
);

    // Rotate taken from the low half of the operand concatenated with itself.
    logic [2*W-1:0] rot_wide;
    assign rot_wide = {data_in, data_in} >> shift;

    always_comb begin
        data_out = data_in;
        case (shift_type)
            LSL:     data_out = data_in << shift;
            LSR:     data_out = data_in >> shift;
            ASR:     data_out = $signed(data_in) >>> shift;
            ROR:     data_out = rot_wide[W-1:0];
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/barrel_arbiter.sv
// rtl/barrel_arbiter.sv - round-robin sharing of one barrel shifter between two requesters
module barrel_arbiter
    import barrel_arbiter_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    barrel_arbiter_if.slave bus
);

    state_e        state_q, state_d;
    logic [1:0]    op_type_q, op_type_d;
    logic [SW-1:0] op_amt_q, op_amt_d;
    logic [W-1:0]  op_din_q, op_din_d;
    logic          gid_q, gid_d;
    logic          last_q, last_d;
    logic [W-1:0]  result_q, result_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          done_q, done_d;
    logic          done_id_q, done_id_d;

    logic [W-1:0]  shift_out;
    logic          grant_valid;
    logic          grant_id;

    barrel_arbiter_shifter barrel (
        .shift_type (op_type_q),
        .shift      (op_amt_q),
        .data_in    (op_din_q),
        .data_out   (shift_out)
    );

    // On contention the requester not served last wins.
    assign grant_valid = bus.req0 | bus.req1;
    assign grant_id    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    always_comb begin
        state_d   = state_q;
        op_type_d = op_type_q;
        op_amt_d  = op_amt_q;
        op_din_d  = op_din_q;
        gid_d     = gid_q;
        last_d    = last_q;
        result_d  = result_q;
        done_id_d = done_id_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    gid_d     = grant_id;
                    op_type_d = grant_id ? bus.type1 : bus.type0;
                    op_amt_d  = grant_id ? bus.amt1  : bus.amt0;
                    op_din_d  = grant_id ? bus.din1  : bus.din0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                result_d  = shift_out;
                ack0_d    = ~gid_q;
                ack1_d    = gid_q;
                done_d    = 1'b1;
                done_id_d = gid_q;
                last_d    = gid_q;
                state_d   = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_type_q <= 2'b00;
            op_amt_q  <= '0;
            op_din_q  <= '0;
            gid_q     <= 1'b0;
            last_q    <= 1'b1;
            result_q  <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_type_q <= op_type_d;
            op_amt_q  <= op_amt_d;
            op_din_q  <= op_din_d;
            gid_q     <= gid_d;
            last_q    <= last_d;
            result_q  <= result_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.result  = result_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_barrel_arbiter.sv
// tb/tb_barrel_arbiter.sv - scoreboard bench for barrel_arbiter
module tb_barrel_arbiter;
    import barrel_arbiter_pkg::*;

    typedef struct {
        logic         id;
        logic [W-1:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    barrel_arbiter_if bus();

    barrel_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", {16'h0, bus.result}, {16'h0, mon_e.res});
                chk("done_id", {31'h0, bus.done_id}, {31'h0, mon_e.id});
                chk("ack0", {31'h0, bus.ack0}, {31'h0, ~mon_e.id});
                chk("ack1", {31'h0, bus.ack1}, {31'h0, mon_e.id});
            end
        end
    end

    task automatic set_req(input logic id, input logic v, input logic [1:0] t,
                           input logic [SW-1:0] a, input logic [W-1:0] d);
        if (id) begin
            bus.req1 = v; bus.type1 = t; bus.amt1 = a; bus.din1 = d;
        end else begin
            bus.req0 = v; bus.type0 = t; bus.amt0 = a; bus.din0 = d;
        end
    endtask

    // Single request from an idle arbiter; checks ack arrives two edges after sampling.
    task automatic do_op(input logic id, input logic [1:0] t, input logic [SW-1:0] a,
                         input logic [W-1:0] d, input logic [W-1:0] r, input bit change);
        int n;
        bit got;
        @(negedge clk);
        set_req(id, 1'b1, t, a, d);
        exp_q.push_back('{id, r});
        @(posedge clk);
        n = 0;
        got = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (change && n == 1) set_req(id, 1'b1, t, a, 16'h1234);
            if ((id ? bus.ack1 : bus.ack0) === 1'b1) got = 1;
        end
        if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        chk("latency", n, 32'd2);
    endtask

    // Both requesters hold req, dropping it for one cycle after each of their acks.
    task automatic run_both(input logic [1:0] t0, input logic [SW-1:0] a0, input logic [W-1:0] d0,
                            input logic [1:0] t1, input logic [SW-1:0] a1, input logic [W-1:0] d1,
                            input int n0, input int n1, input bit spacing);
        int s0;
        int s1;
        int last_ack;
        int k;
        s0 = 0; s1 = 0; last_ack = -1; k = 0;
        @(negedge clk);
        set_req(1'b0, n0 > 0, t0, a0, d0);
        set_req(1'b1, n1 > 0, t1, a1, d1);
        while (!(s0 == n0 && s1 == n1) && k < 60) begin
            @(negedge clk);
            k++;
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                if (spacing && last_ack >= 0) chk("spacing", cycle - last_ack, 32'd3);
                last_ack = cycle;
            end
            if (bus.ack0 === 1'b1) begin
                s0++; bus.req0 = 1'b0;
            end else if (!bus.req0 && s0 < n0) bus.req0 = 1'b1;
            if (bus.ack1 === 1'b1) begin
                s1++; bus.req1 = 1'b0;
            end else if (!bus.req1 && s1 < n1) bus.req1 = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("both_served", {30'h0, s0 == n0, s1 == n1}, 32'd3);
    endtask

    initial begin
        int k;
        set_req(1'b0, 1'b0, 2'b00, '0, '0);
        set_req(1'b1, 1'b0, 2'b00, '0, '0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_result", {16'h0, bus.result}, 32'h0);
        chk("rst_ack0", {31'h0, bus.ack0}, 32'h0);
        chk("rst_ack1", {31'h0, bus.ack1}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_done_id", {31'h0, bus.done_id}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        rst = 1'b0;

        do_op(1'b0, LSL, 4'd4, 16'hF0F0, 16'h0F00, 0);
        do_op(1'b1, LSR, 4'd4, 16'hF0F0, 16'h0F0F, 0);
        do_op(1'b1, ASR, 4'd4, 16'h8080, 16'hF808, 0);

        exp_q.push_back('{1'b0, 16'h0F0F});
        exp_q.push_back('{1'b1, 16'h4040});
        exp_q.push_back('{1'b0, 16'h0F0F});
        run_both(ROR, 4'd4, 16'hF0F0, ROR, 4'd1, 16'h8080, 2, 1, 1);

        do_op(1'b0, LSL, 4'd0, 16'h8080, 16'h8080, 0);
        do_op(1'b0, LSR, 4'd0, 16'h8080, 16'h8080, 0);
        do_op(1'b0, ASR, 4'd0, 16'h8080, 16'h8080, 0);
        do_op(1'b0, ROR, 4'd0, 16'h8080, 16'h8080, 0);
        do_op(1'b1, ROR, 4'd15, 16'h8080, 16'h0101, 0);
        do_op(1'b0, LSR, 4'd4, 16'hF0F0, 16'h0F0F, 1);

        // Abandon an operation mid-flight; requester 0 was served last, so reset must restore the pointer.
        @(negedge clk);
        set_req(1'b0, 1'b1, LSL, 4'd4, 16'hF0F0);
        @(negedge clk);
        chk("abort_busy_pre", {31'h0, bus.busy}, 32'h1);
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("abort_ack0", {31'h0, bus.ack0}, 32'h0);
        chk("abort_result", {16'h0, bus.result}, 32'h0);
        chk("abort_busy", {31'h0, bus.busy}, 32'h0);
        rst = 1'b0;
        exp_q.push_back('{1'b0, 16'h0002});
        exp_q.push_back('{1'b1, 16'h0001});
        run_both(LSL, 4'd1, 16'h0001, LSR, 4'd1, 16'h0002, 1, 1, 0);

        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrel_arbiter.md
Name: barrel_arbiter

Overview:
Shares one 16-bit barrel shifter between two independent requesters (req/ack handshake) with round-robin arbitration.
- Latches the granted requester's operands, drives the shifter, registers its result and returns it with a one-cycle ack/done pulse.
- Sits between client datapaths (e.g. ALU, address unit) and the single shifter instance, so only one shifter is built.

Parameters:
W, 16, data width; fixed to 16 to match the barrel shifter.
SW, 4, shift-amount width; log2(W).

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  synchronous, active-high reset.
req0  input  1  requester 0 request; held high with stable operands until ack0.
type0  input  2  requester 0 shift type: 00 lsl, 01 lsr, 10 asr, 11 ror.
amt0  input  SW  requester 0 shift amount, 0..15.
din0  input  W  requester 0 operand.
ack0  output  1  one-cycle pulse: requester 0's result is valid on result.
req1, type1, amt1, din1  input  1/2/SW/W  requester 1, same as requester 0.
ack1  output  1  one-cycle pulse for requester 1.
result  output  W  registered shifter output; holds until next completion.
done  output  1  one-cycle pulse, equal to ack0 OR ack1.
done_id  output  1  requester served by the current/last completion.
busy  output  1  high in SHIFT and DONE states.

Behaviour:
- Reset state:
  - FSM in IDLE.
  - result=0; ack0=ack1=done=done_id=busy=0.
  - Round-robin pointer last=1, so requester 0 wins the first contention.
  - Operand registers cleared.
- FSM states:
  - IDLE:
    - No req: stay in IDLE.
    - Exactly one req: grant it.
    - Both req: grant the requester != last.
    - On grant: latch type/amt/din of the winner into op registers, record gid, go to SHIFT.
  - SHIFT:
    - Barrel shifter is fed combinationally from the op registers.
    - At the clock edge: result <= shifter output; ack[gid] <= 1; done <= 1; done_id <= gid; last <= gid; go to DONE.
  - DONE:
    - ack/done high for exactly this one cycle.
    - req inputs ignored, which gives the requester one cycle to drop req.
    - Next edge: go to IDLE.
- Latency and throughput:
  - req high at edge k in IDLE -> ack/result valid in the cycle after edge k+1.
  - One operation per 3 cycles.
  - Back-to-back alternating service when both requesters hold req.
- Shift semantics (16-bit, amount 0..15):
  - lsl: zero fill.
  - lsr: zero fill.
  - asr: bit 15 replicated.
  - ror: rotate right.
  - amt=0 passes the operand unchanged for every type.
- Boundary cases:
  - req dropped during SHIFT: operation still completes and ack still pulses; the requester must ignore it.
  - req still high in IDLE after its own ack: treated as a new request. A requester must deassert req within one cycle of ack.
  - Both req, with one of them having been served last: the other wins. No starvation; worst-case wait is one operation.
  - Operand changes after grant: no effect, because operands are latched.
  - Reset asserted in SHIFT or DONE: the operation is abandoned, no ack is issued, and all outputs return to reset values on that edge.
  - Invalid FSM encoding: return to IDLE.

Decomposition:
- Shared package holds:
  - Shift-type constants LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11.
  - FSM state encodings IDLE/SHIFT/DONE.
  - W/SW defaults.
- Sub-module: the existing barrel shifter, instantiated once as barrel (ports: shift_type, shift, data_in, data_out), driven from the op registers.
- Arbitration (pointer and grant logic) stays inline.

Test Plan:
- Reset, then req0 only, type0=lsl, amt0=4, din0=F0F0 -> ack0 pulses 2 cycles after req sampled; result=0F00; done_id=0; ack1 stays 0.
- req1 only, lsr, amt=4, din=F0F0 -> result=0F0F, ack1 pulse; then asr, amt=4, din=8080 -> result=F808.
- req0 and req1 both held high (req0: ror/4/F0F0, req1: ror/1/8080); requesters drop req after each ack and reassert -> grants alternate 0,1,0. Requester 0 gets 0F0F, requester 1 gets 4040. Each completion 3 cycles apart.
- amt=0 for all four types with din=8080 -> result=8080 each time; ror amt=15 on 8080 -> 0101.
- Reset asserted during SHIFT of a req0 operation -> no ack0 pulse; result=0; busy=0 next cycle; first post-reset contention is granted to requester 0.
- Operand change after grant (din0 switched from F0F0 to 1234 during SHIFT) -> result reflects F0F0.
